// File: rtl/lsu.sv
// +--------------------------------------------------------------------------+
// | Module      : lsu                                                        |
// | Description : Load/store unit between EXU and the doubleword memory port.|
// |               One request in flight; IDLE -> ACCESS -> RESP sequencing.  |
// |               Optional LSU_MISALIGN_CHECK_EN enables misalign detection; |
// |               otherwise addresses are forced to natural alignment.       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module lsu (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_misalign,
   output logic [63:0] mem_raddr,
   output logic [63:0] mem_waddr,
   output logic        mem_read,
   output logic        mem_write,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   input  logic [63:0] mem_rdata
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   logic [1:0]  r_state;
   logic [1:0]  w_state_next;

   logic        r_wen;
   logic [63:0] r_addr;
   logic [63:0] r_wdata;
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic        r_misalign;
   logic [63:0] r_rdata;

   logic        w_accept;
   logic [2:0]  w_low_mask;
   logic        w_misalign;
   logic [63:0] w_addr_in;
   logic [2:0]  w_off;
   logic [63:0] w_shifted;
   logic [63:0] w_load_data;
   logic [7:0]  w_mask_base;

   // Address bits that must be zero for a naturally aligned access of req_size.
   always_comb begin
      w_low_mask = 3'b000;
      case (req_size)
         2'd0:    w_low_mask = 3'b000;
         2'd1:    w_low_mask = 3'b001;
         2'd2:    w_low_mask = 3'b011;
         default: w_low_mask = 3'b111;
      endcase
   end

`ifdef LSU_MISALIGN_CHECK_EN
   assign w_misalign = |(req_addr[2:0] & w_low_mask);
   assign w_addr_in  = req_addr;
`else
   assign w_misalign = 1'b0;
   assign w_addr_in  = {req_addr[63:3], req_addr[2:0] & ~w_low_mask};
`endif

   assign w_accept = req_ready && req_valid;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_state_next = w_misalign ? ST_RESP : ST_ACCESS;
            end
         end
         ST_ACCESS: w_state_next = ST_RESP;
         ST_RESP: begin
            if (resp_ready) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // ---------------- output logic ----------------
   // Strobes are gated by rst so no access can leak out while reset is high.
   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      case (r_state)
         ST_IDLE:   req_ready  = !rst;
         ST_ACCESS: begin
            mem_read  = !rst && !r_wen;
            mem_write = !rst &&  r_wen;
         end
         ST_RESP:   resp_valid = 1'b1;
         default:   req_ready  = 1'b0;
      endcase
   end

   // ---------------- datapath ----------------
   assign w_off     = r_addr[2:0];
   assign w_shifted = mem_rdata >> {w_off, 3'b000};

   always_comb begin
      w_load_data = w_shifted;
      case (r_size)
         2'd0:    w_load_data = {{56{!r_unsigned && w_shifted[7]}},  w_shifted[7:0]};
         2'd1:    w_load_data = {{48{!r_unsigned && w_shifted[15]}}, w_shifted[15:0]};
         2'd2:    w_load_data = {{32{!r_unsigned && w_shifted[31]}}, w_shifted[31:0]};
         default: w_load_data = w_shifted;
      endcase
   end

   always_comb begin
      w_mask_base = 8'h00;
      case (r_size)
         2'd0:    w_mask_base = 8'h01;
         2'd1:    w_mask_base = 8'h03;
         2'd2:    w_mask_base = 8'h0F;
         default: w_mask_base = 8'hFF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wen      <= 1'b0;
         r_addr     <= 64'd0;
         r_wdata    <= 64'd0;
         r_size     <= 2'd0;
         r_unsigned <= 1'b0;
         r_misalign <= 1'b0;
         r_rdata    <= 64'd0;
      end else if (w_accept) begin
         r_wen      <= req_wen;
         r_addr     <= w_addr_in;
         r_wdata    <= req_wdata;
         r_size     <= req_size;
         r_unsigned <= req_unsigned;
         r_misalign <= w_misalign;
         r_rdata    <= 64'd0;
      end else if (r_state == ST_ACCESS) begin
         r_rdata    <= r_wen ? 64'd0 : w_load_data;
      end
   end

   assign mem_raddr     = {r_addr[63:3], 3'b000};
   assign mem_waddr     = {r_addr[63:3], 3'b000};
   assign mem_wdata     = r_wdata << {w_off, 3'b000};
   assign mem_wmask     = mem_write ? (w_mask_base << w_off) : 8'h00;
   assign resp_rdata    = r_rdata;
   assign resp_misalign = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_lsu                                                     |
// | Description : Self-checking bench for lsu with a behavioural model.      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_misalign;
   logic [63:0] mem_raddr;
   logic [63:0] mem_waddr;
   logic        mem_read;
   logic        mem_write;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wmask;
   logic [63:0] mem_rdata;

   lsu dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
      .req_unsigned(req_unsigned),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_misalign(resp_misalign),
      .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_read(mem_read),
      .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // observations gathered by the transaction driver
   int          ob_lat, ob_nread, ob_nwrite;
   logic [63:0] ob_raddr, ob_waddr, ob_wdata, ob_rdata;
   logic [7:0]  ob_wmask;
   bit          ob_mis, ob_stable, ob_busy_ready, ob_stray_mask, ob_after_ready;

   // expected values from the model
   bit          e_mis;
   logic [63:0] e_rdata, e_maddr, e_wdata;
   logic [7:0]  e_wmask;
   int          e_lat;

   function automatic void model(input bit wen, input logic [63:0] addr, input logic [63:0] wdata,
                                 input logic [1:0] size, input bit uns, input logic [63:0] rdata,
                                 output bit mis, output logic [63:0] xrdata, output logic [63:0] maddr,
                                 output logic [63:0] xwdata, output logic [7:0] wmask, output int lat);
      int          nbytes;
      int          off;
      bit          chk;
      logic [63:0] ea;
      logic [15:0] m16;
      logic [127:0] keep, v;
      nbytes = 1 << size;
`ifdef LSU_MISALIGN_CHECK_EN
      chk = 1'b1;
`else
      chk = 1'b0;
`endif
      mis   = chk && ((addr % nbytes) != 0);
      ea    = chk ? addr : addr - (addr % nbytes);
      off   = int'(ea % 8);
      maddr = ea - 64'(off);
      m16   = 16'((1 << nbytes) - 1) << off;
      wmask = m16[7:0];
      xwdata = wdata << (8 * off);
      keep  = (128'd1 << (8 * nbytes)) - 128'd1;
      v     = (128'(rdata) >> (8 * off)) & keep;
      if (!uns && v[8 * nbytes - 1]) v = v | ~keep;
      xrdata = (wen || mis) ? 64'd0 : v[63:0];
      lat   = mis ? 1 : 2;
   endfunction

   // Drives one request starting from IDLE (#1 after an edge) and records what the DUT did.
   task automatic run_txn(input bit wen, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [1:0] size, input bit uns, input logic [63:0] rdata,
                          input int delay);
      req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
      req_size = size; req_unsigned = uns; mem_rdata = rdata; resp_ready = 1'b0;
      ob_lat = 99; ob_nread = 0; ob_nwrite = 0; ob_raddr = '0; ob_waddr = '0;
      ob_wdata = '0; ob_wmask = '0; ob_busy_ready = 0; ob_stray_mask = 0; ob_stable = 1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         if (mem_read)  begin ob_nread++;  ob_raddr = mem_raddr; end
         if (mem_write) begin ob_nwrite++; ob_waddr = mem_waddr; ob_wmask = mem_wmask; ob_wdata = mem_wdata; end
         if (!mem_write && mem_wmask != 8'h00) ob_stray_mask = 1;
         if (req_ready) ob_busy_ready = 1;
         if (resp_valid) begin ob_lat = c; break; end
         resp_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      resp_ready = 1'b0;
      ob_rdata = resp_rdata;
      ob_mis   = resp_misalign;
      for (int d = 0; d < delay; d++) begin
         @(posedge clk); #1;
         if (!resp_valid || resp_rdata !== ob_rdata || resp_misalign !== ob_mis ||
             req_ready || mem_read || mem_write) ob_stable = 0;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      ob_after_ready = req_ready && !resp_valid;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h8000_0000;
      req_wdata = '1; req_size = 2'd3; req_unsigned = 1'b0; resp_ready = 1'b0; mem_rdata = '0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (req_ready !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 || resp_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got ready=%b rd=%b wr=%b rv=%b, expected all 0",
                     req_ready, mem_read, mem_write, resp_valid);
         end
         n_checks++;
         if (resp_rdata !== 64'd0 || resp_misalign !== 1'b0 || mem_wmask !== 8'h00 ||
             mem_raddr !== 64'd0 || mem_waddr !== 64'd0 || mem_wdata !== 64'd0) begin
            n_errors++;
            $display("FAIL reset_data: got rdata=%h mis=%b wmask=%h raddr=%h wdata=%h, expected zeros",
                     resp_rdata, resp_misalign, mem_wmask, mem_raddr, mem_wdata);
         end
      end
      rst = 1'b0; req_valid = 1'b0;
      #1;
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_release_ready: got %b expected 1", req_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_signed_byte();
      run_txn(1'b0, 64'h8000_0005, 64'd0, 2'd0, 1'b0, 64'h0000_8000_0000_0000, 0);
      n_checks++;
      if (ob_lat !== 2 || ob_nread !== 1 || ob_nwrite !== 0) begin
         n_errors++;
         $display("FAIL sbyte_timing: got lat=%0d reads=%0d writes=%0d expected 2/1/0", ob_lat, ob_nread, ob_nwrite);
      end
      n_checks++;
      if (ob_raddr !== 64'h8000_0000) begin
         n_errors++;
         $display("FAIL sbyte_raddr: got %h expected 0000000080000000", ob_raddr);
      end
      n_checks++;
      if (ob_rdata !== 64'hFFFF_FFFF_FFFF_FF80 || ob_mis !== 1'b0) begin
         n_errors++;
         $display("FAIL sbyte_rdata: got %h mis=%b expected ffffffffffffff80 mis=0", ob_rdata, ob_mis);
      end
   endtask

   task automatic test_unsigned_half();
      run_txn(1'b0, 64'h8000_0006, 64'd0, 2'd1, 1'b1, 64'hBEEF_0000_0000_0000, 1);
      n_checks++;
      if (ob_rdata !== 64'h0000_0000_0000_BEEF || ob_lat !== 2) begin
         n_errors++;
         $display("FAIL uhalf_rdata: got %h lat=%0d expected 000000000000beef lat=2", ob_rdata, ob_lat);
      end
   endtask

   task automatic test_word_store();
      run_txn(1'b1, 64'h8000_0004, 64'h1234_5678, 2'd2, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 0);
      n_checks++;
      if (ob_nwrite !== 1 || ob_nread !== 0 || ob_wmask !== 8'hF0) begin
         n_errors++;
         $display("FAIL wstore_strobe: got writes=%0d reads=%0d wmask=%h expected 1/0/f0", ob_nwrite, ob_nread, ob_wmask);
      end
      n_checks++;
      if (ob_wdata !== 64'h1234_5678_0000_0000 || ob_waddr !== 64'h8000_0000) begin
         n_errors++;
         $display("FAIL wstore_data: got wdata=%h waddr=%h expected 1234567800000000/80000000", ob_wdata, ob_waddr);
      end
      n_checks++;
      if (ob_rdata !== 64'd0 || ob_mis !== 1'b0 || ob_stray_mask) begin
         n_errors++;
         $display("FAIL wstore_resp: got rdata=%h mis=%b stray=%b expected 0/0/0", ob_rdata, ob_mis, ob_stray_mask);
      end
   endtask

   task automatic test_misalign();
      logic [63:0] rd;
      rd = {$urandom, $urandom};
      model(1'b0, 64'h8000_0002, 64'd0, 2'd2, 1'b0, rd, e_mis, e_rdata, e_maddr, e_wdata, e_wmask, e_lat);
      run_txn(1'b0, 64'h8000_0002, 64'd0, 2'd2, 1'b0, rd, 2);
      n_checks++;
      if (ob_mis !== e_mis || ob_rdata !== e_rdata || ob_lat !== e_lat) begin
         n_errors++;
         $display("FAIL misalign_resp: got mis=%b rdata=%h lat=%0d expected mis=%b rdata=%h lat=%0d",
                  ob_mis, ob_rdata, ob_lat, e_mis, e_rdata, e_lat);
      end
      n_checks++;
      if (ob_nread !== (e_mis ? 0 : 1)) begin
         n_errors++;
         $display("FAIL misalign_reads: got %0d expected %0d", ob_nread, e_mis ? 0 : 1);
      end
   endtask

   task automatic test_backpressure_reset();
      run_txn(1'b0, 64'h8000_0010, 64'd0, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 4);
      n_checks++;
      if (!ob_stable || ob_rdata !== 64'h0123_4567_89AB_CDEF || !ob_after_ready) begin
         n_errors++;
         $display("FAIL backpressure: got stable=%b rdata=%h after_ready=%b expected 1/0123456789abcdef/1",
                  ob_stable, ob_rdata, ob_after_ready);
      end
      req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h8000_0008; req_size = 2'd3; req_wdata = 64'hA5A5_A5A5_5A5A_5A5A;
      #1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n_checks++;
      if (mem_write !== 1'b1) begin
         n_errors++;
         $display("FAIL rst_access_pre: got mem_write=%b expected 1", mem_write);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (mem_write !== 1'b0 || mem_read !== 1'b0 || mem_wmask !== 8'h00) begin
         n_errors++;
         $display("FAIL rst_access_gate: got wr=%b rd=%b wmask=%h expected 0/0/00", mem_write, mem_read, mem_wmask);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      n_checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_wdata !== 64'd0) begin
         n_errors++;
         $display("FAIL rst_access_idle: got ready=%b rv=%b wdata=%h expected 1/0/0", req_ready, resp_valid, mem_wdata);
      end
      @(posedge clk); #1;
      n_checks++;
      if (resp_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL rst_access_drop: got resp_valid=%b expected 0", resp_valid);
      end
   endtask

   task automatic test_back_to_back();
      int accepted;
      accepted = 0;
      req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h8000_0010; req_size = 2'd3;
      req_unsigned = 1'b0; mem_rdata = 64'h1111_2222_3333_4444; resp_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (req_valid && req_ready) accepted++;
         @(posedge clk); #1;
      end
      req_valid = 1'b0; resp_ready = 1'b0;
      n_checks++;
      if (accepted !== 3) begin
         n_errors++;
         $display("FAIL back_to_back: got %0d accepts in 9 cycles expected 3", accepted);
      end
   endtask

   task automatic test_random();
      bit          wen, uns;
      logic [63:0] addr, wd, rd;
      logic [1:0]  sz;
      for (int t = 0; t < 200; t++) begin
         wen  = 1'($urandom_range(0, 1));
         uns  = 1'($urandom_range(0, 1));
         sz   = 2'($urandom_range(0, 3));
         addr = 64'h8000_0000 + 64'($urandom_range(0, 255));
         wd   = {$urandom, $urandom};
         rd   = {$urandom, $urandom};
         model(wen, addr, wd, sz, uns, rd, e_mis, e_rdata, e_maddr, e_wdata, e_wmask, e_lat);
         run_txn(wen, addr, wd, sz, uns, rd, int'($urandom_range(0, 3)));
         n_checks++;
         if (ob_lat !== e_lat || ob_mis !== e_mis || ob_rdata !== e_rdata) begin
            n_errors++;
            $display("FAIL rand_resp[%0d]: got lat=%0d mis=%b rdata=%h expected lat=%0d mis=%b rdata=%h",
                     t, ob_lat, ob_mis, ob_rdata, e_lat, e_mis, e_rdata);
         end
         n_checks++;
         if (ob_nread !== ((!wen && !e_mis) ? 1 : 0) || ob_nwrite !== ((wen && !e_mis) ? 1 : 0)) begin
            n_errors++;
            $display("FAIL rand_strobes[%0d]: got reads=%0d writes=%0d wen=%b mis=%b", t, ob_nread, ob_nwrite, wen, e_mis);
         end
         if (!e_mis) begin
            n_checks++;
            if (wen ? (ob_waddr !== e_maddr || ob_wmask !== e_wmask || ob_wdata !== e_wdata)
                    : (ob_raddr !== e_maddr)) begin
               n_errors++;
               $display("FAIL rand_mem[%0d]: got addr=%h wmask=%h wdata=%h expected addr=%h wmask=%h wdata=%h",
                        t, wen ? ob_waddr : ob_raddr, ob_wmask, ob_wdata, e_maddr, e_wmask, e_wdata);
            end
         end
         n_checks++;
         if (!ob_stable || ob_busy_ready || ob_stray_mask || !ob_after_ready) begin
            n_errors++;
            $display("FAIL rand_handshake[%0d]: got stable=%b busy_ready=%b stray=%b after_ready=%b expected 1/0/0/1",
                     t, ob_stable, ob_busy_ready, ob_stray_mask, ob_after_ready);
         end
      end
   endtask

   initial begin
      test_reset();
      test_signed_byte();
      test_unsigned_half();
      test_word_store();
      test_misalign();
      test_backpressure_reset();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/lsu.md
# lsu

Load/store unit between the execute stage and the DPI memory blackbox. It accepts one load or store request at a time from EXU and drives the blackbox's doubleword-aligned memory port (mem_raddr/mem_read/mem_waddr/mem_wdata/mem_wmask/mem_write/mem_rdata). For loads it extracts, sign- or zero-extends and registers the data. It returns a response to WBU over a valid/ready handshake.

## Interface
Parameters:
- none

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  EXU has a request.
- req_ready  out  1  LSU accepts a request this cycle.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data, right-aligned.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- req_unsigned  in  1  zero-extend the load; ignored for stores and dword loads.
- resp_valid  out  1  response available.
- resp_ready  in  1  WBU takes the response.
- resp_rdata  out  64  extended load data; 0 for stores.
- resp_misalign  out  1  request was misaligned; no memory access was made.
- mem_raddr, mem_waddr  out  64  latched address with bits [2:0] cleared.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_wdata  out  64  store data shifted into its byte lanes.
- mem_wmask  out  8  byte-lane enables.
- mem_rdata  in  64  combinational read data from the blackbox, valid in the same cycle as mem_read.

## Operation
State machine: IDLE, ACCESS, RESP.
- IDLE
  - req_ready = 1.
  - On req_valid, latch wen, addr, wdata, size and unsigned, then compute misalignment.
  - Misaligned means addr & ((1<<size)-1) != 0.
  - Misaligned: go to RESP with misalign = 1 and rdata = 0.
  - Otherwise go to ACCESS.
- ACCESS (exactly one cycle)
  - Load: mem_read = 1. At the clock edge, capture the extracted mem_rdata into resp_rdata.
  - Store: mem_write = 1 and resp_rdata = 0.
  - Always go to RESP.
- RESP
  - resp_valid = 1.
  - On resp_ready, go to IDLE. Otherwise hold, with all response outputs stable.
- req_ready is 0 in ACCESS and RESP. A request presented then is not accepted and must be held by EXU.
- Arithmetic, with off = addr[2:0] and nbytes = 1<<size:
  - mem_wmask = ((1<<nbytes)-1) << off, truncated to 8 bits. It is nonzero only in a store ACCESS.
  - mem_wdata = wdata << (8*off), truncated to 64 bits.
  - Load data: shifted = mem_rdata >> (8*off), then keep the low 8*nbytes bits.
  - Extension: sign-extend from the top kept bit unless unsigned, in which case zero-extend.
- mem_raddr and mem_waddr are always driven from the latched address, including outside ACCESS.

## Timing
- Reset values:
  - state = IDLE; req_ready = 1 once rst is low.
  - resp_valid = 0, resp_rdata = 0, resp_misalign = 0.
  - mem_read = 0, mem_write = 0, mem_wmask = 0.
  - mem_raddr, mem_waddr and mem_wdata = 0 (latched fields cleared).
- mem_read and mem_write are gated by !rst. No memory access occurs in any cycle where rst is high, including a reset asserted while in ACCESS.
- Aligned request accepted at edge N:
  - ACCESS during cycle N+1.
  - resp_valid from cycle N+2.
  - Next request accepted no earlier than the edge ending the resp_ready cycle. Minimum is 3 cycles per request.
- Misaligned request: resp_valid from cycle N+1, with zero memory strobes.
- resp_ready while resp_valid = 0 is ignored.
- Reset mid-operation: state returns to IDLE at the next edge. Any pending response is dropped and resp_valid = 0.

## Configuration
- LSU_MISALIGN_CHECK_EN defined: misalignment detection as described above.
- LSU_MISALIGN_CHECK_EN undefined:
  - resp_misalign is tied 0 and every request goes through ACCESS.
  - The latched address has its low log2(nbytes) bits cleared, i.e. it is forced to natural alignment before off is computed.

## Test plan
- Reset: hold rst for 2 cycles while req_valid = 1 -> req_ready = 0, no strobes, resp_valid = 0. After release, req_ready = 1.
- Signed byte load: addr = 0x80000005, size = 0, unsigned = 0, mem_rdata = 0x0000_8000_0000_0000 -> mem_raddr = 0x80000000, mem_read = 1 for one cycle, resp_rdata = 0xFFFF_FFFF_FFFF_FF80 at N+2.
- Unsigned half load: addr = 0x80000006, size = 1, unsigned = 1, mem_rdata = 0xBEEF_0000_0000_0000 -> resp_rdata = 0x0000_0000_0000_BEEF.
- Word store: addr = 0x80000004, size = 2, wdata = 0x1234_5678 -> one cycle with mem_write = 1, mem_wmask = 0xF0, mem_wdata = 0x1234_5678_0000_0000. Response has resp_rdata = 0, resp_misalign = 0.
- Misaligned with LSU_MISALIGN_CHECK_EN defined: word load at addr = 0x80000002 -> no mem_read, resp_valid at N+1 with resp_misalign = 1 and resp_rdata = 0.
- Backpressure and reset: hold resp_ready = 0 for 4 cycles -> resp_valid and resp_rdata stable, req_ready = 0. Then assert rst while in ACCESS of a store -> mem_write = 0 in that cycle and state = IDLE after the edge.
